// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one memory bus between the CPU fetch (I) and data (D) ports.
// One request buffer per port; D has priority, with a starvation guard that protects I.
module cpu_mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_request,
   input  logic [31:0] i_addr,
   output logic        i_busy,
   output logic        i_valid,
   output logic [31:0] i_rdata,
   input  logic        d_request,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_read_pending,
   output logic        d_write_pending,
   output logic [31:0] d_rdata,
   output logic        bus_request,
   output logic        bus_write,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int unsigned   CW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] starve_q, starve_d;

   // Request buffers
   logic          i_full_q, i_full_d;
   logic [31:0]   i_addr_q, i_addr_d;
   logic          d_full_q, d_full_d;
   logic          d_write_q, d_write_d;
   logic [31:0]   d_addr_q, d_addr_d;
   logic [31:0]   d_wdata_q, d_wdata_d;
   logic [3:0]    d_wstrb_q, d_wstrb_d;

   // Registered bus and response outputs
   logic          bus_request_q, bus_request_d;
   logic          bus_write_q, bus_write_d;
   logic [31:0]   bus_addr_q, bus_addr_d;
   logic [31:0]   bus_wdata_q, bus_wdata_d;
   logic [3:0]    bus_wstrb_q, bus_wstrb_d;
   logic          i_valid_q, i_valid_d;
   logic [31:0]   i_rdata_q, i_rdata_d;
   logic [31:0]   d_rdata_q, d_rdata_d;

   logic          i_release, d_release;
   logic          i_cap, d_cap;
   logic          arb, i_elig, d_elig;
   logic          grant_i, grant_d;

   // Buffer bookkeeping: release on own ack, capture when empty or released this cycle.
   always_comb begin
      // NOTE: every signal gets a default at the top of a combinational block so no path infers a latch.
      i_release = bus_ack && (state_q == GNT_I);
      d_release = bus_ack && (state_q == GNT_D);
      i_cap     = i_request && (!i_full_q || i_release);
      d_cap     = d_request && (!d_full_q || d_release);

      i_full_d  = i_cap || (i_full_q && !i_release);
      i_addr_d  = i_cap ? i_addr : i_addr_q;

      d_full_d  = d_cap || (d_full_q && !d_release);
      d_write_d = d_cap ? d_write : d_write_q;
      d_addr_d  = d_cap ? d_addr  : d_addr_q;
      d_wdata_d = d_cap ? d_wdata : d_wdata_q;
      d_wstrb_d = d_cap ? d_wstrb : d_wstrb_q;
   end

   // Next-state: arbitrate from IDLE on registered occupancy, or on ack including same-edge captures.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      arb      = 1'b0;
      i_elig   = 1'b0;
      d_elig   = 1'b0;
      grant_i  = 1'b0;
      grant_d  = 1'b0;

      case (state_q)
         IDLE: begin
            arb    = 1'b1;
            i_elig = i_full_q;
            d_elig = d_full_q;
         end
         GNT_I, GNT_D: begin
            if (bus_ack) begin
               arb    = 1'b1;
               i_elig = i_full_d;
               d_elig = d_full_d;
            end
         end
         default: ;
      endcase

      if (arb) begin
         if (i_elig && (!d_elig || (starve_q == STARVE_MAX))) begin
            grant_i = 1'b1;
            state_d = GNT_I;
         end else if (d_elig) begin
            grant_d = 1'b1;
            state_d = GNT_D;
         end else begin
            state_d = IDLE;
         end
      end

      if (grant_i) begin
         starve_d = '0;
      end else if (grant_d && i_elig) begin
         starve_d = starve_q + CW'(1);
      end else if (!i_full_q) begin
         starve_d = '0;
      end
   end

   // Outputs: bus fields load only on a grant and are cleared when the bus goes idle.
   always_comb begin
      bus_request_d = bus_request_q;
      bus_write_d   = bus_write_q;
      bus_addr_d    = bus_addr_q;
      bus_wdata_d   = bus_wdata_q;
      bus_wstrb_d   = bus_wstrb_q;

      if (grant_i) begin
         bus_request_d = 1'b1;
         bus_write_d   = 1'b0;
         bus_addr_d    = i_addr_d;
         bus_wdata_d   = '0;
         bus_wstrb_d   = '0;
      end else if (grant_d) begin
         bus_request_d = 1'b1;
         bus_write_d   = d_write_d;
         bus_addr_d    = d_addr_d;
         bus_wdata_d   = d_write_d ? d_wdata_d : '0;
         bus_wstrb_d   = d_write_d ? d_wstrb_d : '0;
      end else if (arb) begin
         bus_request_d = 1'b0;
         bus_write_d   = 1'b0;
         bus_addr_d    = '0;
         bus_wdata_d   = '0;
         bus_wstrb_d   = '0;
      end

      i_valid_d = i_release;
      i_rdata_d = i_release ? bus_rdata : i_rdata_q;
      d_rdata_d = (d_release && !d_write_q) ? bus_rdata : d_rdata_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_q      <= '0;
         i_full_q      <= 1'b0;
         i_addr_q      <= '0;
         d_full_q      <= 1'b0;
         d_write_q     <= 1'b0;
         d_addr_q      <= '0;
         d_wdata_q     <= '0;
         d_wstrb_q     <= '0;
         bus_request_q <= 1'b0;
         bus_write_q   <= 1'b0;
         bus_addr_q    <= '0;
         bus_wdata_q   <= '0;
         bus_wstrb_q   <= '0;
         i_valid_q     <= 1'b0;
         i_rdata_q     <= '0;
         d_rdata_q     <= '0;
      end else begin
         starve_q      <= starve_d;
         i_full_q      <= i_full_d;
         i_addr_q      <= i_addr_d;
         d_full_q      <= d_full_d;
         d_write_q     <= d_write_d;
         d_addr_q      <= d_addr_d;
         d_wdata_q     <= d_wdata_d;
         d_wstrb_q     <= d_wstrb_d;
         bus_request_q <= bus_request_d;
         bus_write_q   <= bus_write_d;
         bus_addr_q    <= bus_addr_d;
         bus_wdata_q   <= bus_wdata_d;
         bus_wstrb_q   <= bus_wstrb_d;
         i_valid_q     <= i_valid_d;
         i_rdata_q     <= i_rdata_d;
         d_rdata_q     <= d_rdata_d;
      end
   end

   assign i_busy          = i_full_q;
   assign i_valid         = i_valid_q;
   assign i_rdata         = i_rdata_q;
   assign d_read_pending  = d_full_q && !d_write_q;
   assign d_write_pending = d_full_q && d_write_q;
   assign d_rdata         = d_rdata_q;
   assign bus_request     = bus_request_q;
   assign bus_write       = bus_write_q;
   assign bus_addr        = bus_addr_q;
   assign bus_wdata       = bus_wdata_q;
   assign bus_wstrb       = bus_wstrb_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Testbench for cpu_mem_arbiter: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a transaction-level model of the two ports.
module tb_cpu_mem_arbiter;

   localparam int STARVE_LIMIT = 4;

   logic        clock, reset;
   logic        i_request;
   logic [31:0] i_addr;
   logic        i_busy, i_valid;
   logic [31:0] i_rdata;
   logic        d_request, d_write;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_read_pending, d_write_pending;
   logic [31:0] d_rdata;
   logic        bus_request, bus_write;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   cpu_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clock(clock), .reset(reset),
      .i_request(i_request), .i_addr(i_addr), .i_busy(i_busy), .i_valid(i_valid), .i_rdata(i_rdata),
      .d_request(d_request), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_read_pending(d_read_pending), .d_write_pending(d_write_pending), .d_rdata(d_rdata),
      .bus_request(bus_request), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one slot per port, an owner of the bus, and a starvation counter.
   typedef struct packed {
      logic        full;
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   req_t        m_i, m_d;
   int          m_owner;   // 0 = nobody, 1 = I, 2 = D
   int          m_starve;
   logic        m_breq, m_bwr;
   logic [31:0] m_baddr, m_bwdata;
   logic [3:0]  m_bwstrb;
   logic        m_i_valid;
   logic [31:0] m_i_rdata, m_d_rdata;
   bit          m_was_idle, m_ack, m_i_cand, m_d_cand;

   always @(posedge clock) begin
      if (reset) begin
         m_i = '0; m_d = '0; m_owner = 0; m_starve = 0;
         m_breq = 0; m_bwr = 0; m_baddr = '0; m_bwdata = '0; m_bwstrb = '0;
         m_i_valid = 0; m_i_rdata = '0; m_d_rdata = '0;
      end else begin
         m_was_idle = (m_owner == 0);
         m_i_cand   = m_i.full;
         m_d_cand   = m_d.full;
         m_ack      = bus_ack && !m_was_idle;
         m_i_valid  = 1'b0;
         if (m_ack && m_owner == 1) begin
            m_i_rdata = bus_rdata;
            m_i_valid = 1'b1;
            m_i.full  = 1'b0;
         end else if (m_ack && m_owner == 2) begin
            if (!m_d.write) m_d_rdata = bus_rdata;
            m_d.full = 1'b0;
         end
         if (i_request && !m_i.full)
            m_i = '{full: 1'b1, write: 1'b0, addr: i_addr, wdata: '0, wstrb: '0};
         if (d_request && !m_d.full)
            m_d = '{full: 1'b1, write: d_write, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
         if (m_ack) begin
            m_i_cand = m_i.full;
            m_d_cand = m_d.full;
         end
         if (m_was_idle || m_ack) begin
            if (m_i_cand && (!m_d_cand || m_starve == STARVE_LIMIT)) begin
               m_owner = 1; m_starve = 0;
               m_breq = 1; m_bwr = 0; m_baddr = m_i.addr; m_bwdata = '0; m_bwstrb = '0;
            end else if (m_d_cand) begin
               if (m_i_cand) m_starve = m_starve + 1;
               m_owner = 2;
               m_breq = 1; m_bwr = m_d.write; m_baddr = m_d.addr; m_bwdata = m_d.wdata;
               m_bwstrb = m_d.write ? m_d.wstrb : 4'b0000;
            end else begin
               m_owner = 0; m_breq = 0;
            end
         end
         if (!m_i.full) m_starve = 0;
      end
   end

   always @(negedge clock) begin
      if (cmp_en && !reset) begin
         check("bus_request", 32'(bus_request), 32'(m_breq));
         if (m_breq) begin
            check("bus_write", 32'(bus_write), 32'(m_bwr));
            check("bus_addr", bus_addr, m_baddr);
            check("bus_wstrb", 32'(bus_wstrb), 32'(m_bwstrb));
            if (m_bwr) check("bus_wdata", bus_wdata, m_bwdata);
         end
         check("i_busy", 32'(i_busy), 32'(m_i.full));
         check("i_valid", 32'(i_valid), 32'(m_i_valid));
         check("i_rdata", i_rdata, m_i_rdata);
         check("d_read_pending", 32'(d_read_pending), 32'(m_d.full && !m_d.write));
         check("d_write_pending", 32'(d_write_pending), 32'(m_d.full && m_d.write));
         check("d_rdata", d_rdata, m_d_rdata);
      end
   end

   task automatic pulse_d(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      d_request = 1'b1; d_write = wr; d_addr = a; d_wdata = wd; d_wstrb = ws;
      @(negedge clock);
      d_request = 1'b0;
   endtask

   task automatic drain();
      bus_ack = 1'b1;
      for (int k = 0; k < 20 && (bus_request || i_busy || d_read_pending || d_write_pending); k++)
         @(negedge clock);
      bus_ack = 1'b0;
      check("drain_idle", {28'd0, bus_request, i_busy, d_read_pending, d_write_pending}, 32'd0);
   endtask

   int          cnt, n_req, n_d_before, i_pos, n_ival;
   bit          prev_req, d_after_i;
   int          i_pct, d_pct, a_pct;

   initial begin
      reset = 1'b1;
      i_request = 0; i_addr = '0; d_request = 0; d_write = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
      bus_ack = 0; bus_rdata = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // Reset state
      check("rst_bus_request", 32'(bus_request), 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
      check("rst_flags", {27'd0, i_busy, i_valid, d_read_pending, d_write_pending, bus_write}, 32'd0);
      check("rst_rdata", i_rdata | d_rdata | bus_wdata, 32'd0);
      cmp_en = 1'b1;

      // Single load: ack three cycles after bus_request rises
      pulse_d(1'b0, 32'h100, 32'h0, 4'h0);
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         if (d_read_pending) cnt++;
         if (k == 1) begin
            check("load_bus_request", 32'(bus_request), 32'd1);
            check("load_bus_addr", bus_addr, 32'h100);
            check("load_bus_wstrb", 32'(bus_wstrb), 32'd0);
         end
         bus_ack = (k == 3);
         bus_rdata = (k == 3) ? 32'hDEADBEEF : 32'h0;
         @(negedge clock);
      end
      check("load_pending_cycles", 32'(cnt), 32'd4);
      check("load_d_rdata", d_rdata, 32'hDEADBEEF);
      check("model_load_d_rdata", m_d_rdata, 32'hDEADBEEF);

      // Store: fields stay stable while waiting for ack
      pulse_d(1'b1, 32'h204, 32'h11223344, 4'b0011);
      for (int k = 0; k < 6; k++) begin
         if (k == 0) check("store_write_pending", 32'(d_write_pending), 32'd1);
         if (k >= 1 && k <= 4) begin
            check("store_bus_request", 32'(bus_request), 32'd1);
            check("store_bus_write", 32'(bus_write), 32'd1);
            check("store_bus_addr", bus_addr, 32'h204);
            check("store_bus_wdata", bus_wdata, 32'h11223344);
            check("store_bus_wstrb", 32'(bus_wstrb), 32'h3);
         end
         if (k == 5) begin
            check("store_pending_clear", 32'(d_write_pending), 32'd0);
            check("store_d_rdata_kept", d_rdata, 32'hDEADBEEF);
         end
         bus_ack = (k == 4);
         @(negedge clock);
      end
      drain();

      // Collision: D first, then I back-to-back
      i_request = 1; i_addr = 32'h40; d_request = 1; d_write = 0; d_addr = 32'h80;
      bus_ack = 1; bus_rdata = 32'hA00000FF;
      @(negedge clock);
      i_request = 0; d_request = 0;
      n_ival = 0;
      for (int k = 0; k < 6; k++) begin
         if (i_valid) n_ival++;
         if (k == 1 || k == 2) check("coll_bus_request", 32'(bus_request), 32'd1);
         if (k == 1) check("coll_first_addr", bus_addr, 32'h80);
         if (k == 2) check("coll_second_addr", bus_addr, 32'h40);
         bus_rdata = 32'hA0000000 | 32'(k);
         @(negedge clock);
      end
      check("coll_i_valid_pulses", 32'(n_ival), 32'd1);
      check("coll_i_rdata", i_rdata, 32'hA0000002);
      check("coll_d_rdata", d_rdata, 32'hA0000001);
      check("model_coll_i_rdata", m_i_rdata, 32'hA0000002);
      drain();

      // Starvation: I waits while D re-requests on every ack
      i_request = 1; i_addr = 32'h500; d_request = 1; d_write = 0; d_addr = 32'h600; bus_ack = 1;
      @(negedge clock);
      i_request = 0;
      n_d_before = 0; i_pos = -1; d_after_i = 0;
      for (int k = 0; k < 14; k++) begin
         if (bus_request) begin
            if (bus_addr == 32'h500) begin
               if (i_pos < 0) i_pos = k;
            end else if (i_pos < 0) begin
               n_d_before++;
            end else if (k == i_pos + 1) begin
               d_after_i = 1;
            end
         end
         d_request = (k < 7);
         d_addr = 32'h600 + 32'(16 * (k + 1));
         @(negedge clock);
      end
      d_request = 0;
      check("starve_d_before_i", 32'(n_d_before), 32'(STARVE_LIMIT));
      check("starve_i_slot", 32'(i_pos), 32'd5);
      check("starve_d_resumes", 32'(d_after_i), 32'd1);
      drain();

      // Ignored duplicate request while the load is still pending
      pulse_d(1'b0, 32'h700, 32'h0, 4'h0);
      d_request = 1; d_addr = 32'h7FC;
      @(negedge clock);
      d_request = 0;
      n_req = 0; prev_req = 0;
      for (int k = 1; k < 9; k++) begin
         if (bus_request && !prev_req) begin
            n_req++;
            check("dup_bus_addr", bus_addr, 32'h700);
         end
         prev_req = bus_request;
         bus_ack = (k == 2);
         bus_rdata = 32'h77770000;
         @(negedge clock);
      end
      check("dup_transactions", 32'(n_req), 32'd1);
      check("dup_d_rdata", d_rdata, 32'h77770000);
      drain();

      // Reset while GNT_D waits for ack, then a late ack
      pulse_d(1'b0, 32'h300, 32'h0, 4'h0);
      @(negedge clock);
      check("rstmid_active", 32'(bus_request), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("rstmid_bus_request", 32'(bus_request), 32'd0);
      check("rstmid_flags", {28'd0, i_busy, d_read_pending, d_write_pending, bus_write}, 32'd0);
      check("rstmid_bus_addr", bus_addr, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      bus_ack = 1; bus_rdata = 32'hBAD0BAD0;
      @(negedge clock);
      bus_ack = 0;
      check("late_ack_bus_request", 32'(bus_request), 32'd0);
      check("late_ack_d_rdata", d_rdata, 32'd0);
      check("late_ack_flags", {29'd0, i_valid, d_read_pending, i_busy}, 32'd0);

      // Random traffic with varying request and ack rates
      for (int blk = 0; blk < 4; blk++) begin
         case (blk)
            0:       begin i_pct = 25; d_pct = 30; a_pct = 50; end
            1:       begin i_pct = 60; d_pct = 80; a_pct = 90; end
            2:       begin i_pct = 10; d_pct = 50; a_pct = 30; end
            default: begin i_pct = 50; d_pct = 50; a_pct = 100; end
         endcase
         for (int c = 0; c < 700; c++) begin
            i_request = ($urandom_range(99) < i_pct);
            i_addr    = $urandom & 32'hFFFF_FFFC;
            d_request = ($urandom_range(99) < d_pct);
            d_write   = $urandom_range(1);
            d_addr    = $urandom;
            d_wdata   = $urandom;
            d_wstrb   = 4'($urandom_range(15));
            bus_ack   = ($urandom_range(99) < a_pct);
            bus_rdata = $urandom;
            @(negedge clock);
         end
      end
      i_request = 0; d_request = 0;
      drain();
      @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
